// File: rtl/instruction_memory_sync.sv
// ---------------------------------------------------------------------------
// instruction_memory_sync
//
// Loadable instruction memory with a registered fetch port for the IF stage.
// After reset a boot loader fills the array through the load port (LOAD
// state). After load_done, each rising edge performs a fetch (RUN state).
// A fetch has one cycle of latency. It supports freeze (stall) and flush
// (squash). A misaligned or out-of-range PC returns NOP_WORD and raises
// addr_fault.
//
// Ports
//   clk          system clock; all state changes on the rising edge
//   rst          synchronous active-high reset (memory contents retained)
//   load_en      write load_data at load_addr (accepted in LOAD only)
//   load_addr    byte address of the word being loaded
//   load_data    word to store
//   load_done    end of program load; LOAD -> RUN
//   freeze       hold all fetch outputs
//   flush        squash the fetch (NOP, instr_valid=0); overrides freeze
//   PC           fetch byte address
//   Instruction  registered fetched word
//   instr_valid  Instruction holds a real fetched word
//   addr_fault   last fetch was misaligned or out of range
//   running      1 while in RUN (also serves as the state debug view)
//   load_count   number of accepted load writes, saturating at DEPTH
//   load_error   sticky: a load write was rejected
//
// Handshake: this block has no valid/ready handshake. load_en is a one-cycle
// write strobe. It is acted on at the edge where it is sampled high, and the
// source is never back-pressured. A rejected write only sets load_error.
// ---------------------------------------------------------------------------
module instruction_memory_sync #(
    parameter int                    WORD_WIDTH    = 32,
    parameter int                    DEPTH         = 64,
    parameter int                    ADDR_WIDTH    = 32,
    parameter logic [WORD_WIDTH-1:0] NOP_WORD      = 32'hE1A00000,
    parameter bit                    LOAD_ON_RESET = 1'b1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         load_en,
    input  logic [ADDR_WIDTH-1:0]        load_addr,
    input  logic [WORD_WIDTH-1:0]        load_data,
    input  logic                         load_done,
    input  logic                         freeze,
    input  logic                         flush,
    input  logic [ADDR_WIDTH-1:0]        PC,
    output logic [WORD_WIDTH-1:0]        Instruction,
    output logic                         instr_valid,
    output logic                         addr_fault,
    output logic                         running,
    output logic [$clog2(DEPTH):0]       load_count,
    output logic                         load_error
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int IDX_W = $clog2(DEPTH);

    typedef enum logic {
        ST_LOAD = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    localparam state_e RESET_STATE = LOAD_ON_RESET ? ST_LOAD : ST_RUN;

    // A word address is usable when it is word aligned and its index lies
    // inside the array. Large addresses never wrap; they simply fail.
    function automatic logic addr_ok(input logic [ADDR_WIDTH-1:0] a);
        return (a[1:0] == 2'b00) && ((a >> 2) < ADDR_WIDTH'(DEPTH));
    endfunction

    // The array is preloaded with NOP_WORD at configuration time. rst does
    // not touch it, so a program survives a reset.
    logic [WORD_WIDTH-1:0] mem_q [DEPTH] = '{default: NOP_WORD};

    state_e                state_q, state_d;
    logic [WORD_WIDTH-1:0] instr_q, instr_d;
    logic                  valid_q, valid_d;
    logic                  fault_q, fault_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  err_q,   err_d;
    logic                  mem_we;

    logic [IDX_W-1:0]      load_idx;
    logic [IDX_W-1:0]      pc_idx;

    assign load_idx = load_addr[IDX_W+1:2];
    assign pc_idx   = PC[IDX_W+1:2];

    always_comb begin
        state_d = state_q;
        instr_d = instr_q;
        valid_d = valid_q;
        fault_d = fault_q;
        count_d = count_q;
        err_d   = err_q;
        mem_we  = 1'b0;

        case (state_q)
            ST_LOAD: begin
                // Fetch is disabled: outputs sit at their reset values.
                instr_d = NOP_WORD;
                valid_d = 1'b0;
                fault_d = 1'b0;
                if (load_en) begin
                    if (addr_ok(load_addr)) begin
                        mem_we = 1'b1;
                        if (count_q != CNT_W'(DEPTH)) begin
                            count_d = count_q + CNT_W'(1);
                        end
                    end else begin
                        err_d = 1'b1;
                    end
                end
                // A write in the same cycle as load_done still lands.
                if (load_done) begin
                    state_d = ST_RUN;
                end
            end

            ST_RUN: begin
                if (load_en) begin
                    err_d = 1'b1;
                end
                if (flush) begin
                    instr_d = NOP_WORD;
                    valid_d = 1'b0;
                    fault_d = 1'b0;
                end else if (!freeze) begin
                    valid_d = 1'b1;
                    if (addr_ok(PC)) begin
                        instr_d = mem_q[pc_idx];
                        fault_d = 1'b0;
                    end else begin
                        instr_d = NOP_WORD;
                        fault_d = 1'b1;
                    end
                end
            end

            default: begin
                state_d = RESET_STATE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RESET_STATE;
            instr_q <= NOP_WORD;
            valid_q <= 1'b0;
            fault_q <= 1'b0;
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
            fault_q <= fault_d;
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

    // Reset wins over a coincident load write.
    always_ff @(posedge clk) begin
        if (mem_we && !rst) begin
            mem_q[load_idx] <= load_data;
        end
    end

    assign Instruction = instr_q;
    assign instr_valid = valid_q;
    assign addr_fault  = fault_q;
    assign running     = (state_q == ST_RUN);
    assign load_count  = count_q;
    assign load_error  = err_q;

endmodule

// File: tb/tb_instruction_memory_sync.sv
module tb_instruction_memory_sync;

    localparam int          W     = 32;
    localparam int          AW    = 32;
    localparam int          DEPTH = 64;
    localparam logic [31:0] NOP   = 32'hE1A00000;

    // ---------------- clock / reset / DUT ----------------
    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          load_en = 1'b0;
    logic [AW-1:0] load_addr = '0;
    logic [W-1:0]  load_data = '0;
    logic          load_done = 1'b0;
    logic          freeze = 1'b0;
    logic          flush = 1'b0;
    logic [AW-1:0] PC = '0;
    logic [W-1:0]  Instruction;
    logic          instr_valid;
    logic          addr_fault;
    logic          running;
    logic [6:0]    load_count;
    logic          load_error;

    always #5 clk = ~clk;

    instruction_memory_sync #(
        .WORD_WIDTH(W), .DEPTH(DEPTH), .ADDR_WIDTH(AW),
        .NOP_WORD(NOP), .LOAD_ON_RESET(1'b1)
    ) dut (
        .clk(clk), .rst(rst),
        .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
        .load_done(load_done), .freeze(freeze), .flush(flush), .PC(PC),
        .Instruction(Instruction), .instr_valid(instr_valid),
        .addr_fault(addr_fault), .running(running),
        .load_count(load_count), .load_error(load_error)
    );

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard / reference model ----------------
    int n_checks = 0;
    int n_fail   = 0;

    logic [33:0] exp_q[$];            // {instr_valid, addr_fault, Instruction}
    logic [31:0] mdl_mem [DEPTH];
    logic [33:0] mdl_out;
    logic        mdl_run;
    int          mdl_cnt;
    logic        mdl_err;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic good_addr(input logic [31:0] a);
        return (a[1:0] == 2'b00) && ((a >> 2) < DEPTH);
    endfunction

    task automatic check_status(input string tag);
        check({tag, ".running"}, 64'(running), 64'(mdl_run));
        check({tag, ".count"}, 64'(load_count), 64'(mdl_cnt));
        check({tag, ".error"}, 64'(load_error), 64'(mdl_err));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        mdl_run = 1'b0;
        mdl_cnt = 0;
        mdl_err = 1'b0;
        mdl_out = {1'b0, 1'b0, NOP};
        check("rst.instr", 64'(Instruction), 64'(NOP));
        check("rst.valid", 64'(instr_valid), 64'd0);
        check("rst.fault", 64'(addr_fault), 64'd0);
        check_status("rst");
    endtask

    task automatic load_word(input logic [31:0] a, input logic [31:0] d, input logic done);
        load_en = 1'b1;
        load_addr = a;
        load_data = d;
        load_done = done;
        if (!mdl_run && good_addr(a)) begin
            mdl_mem[int'(a >> 2)] = d;
            if (mdl_cnt < DEPTH) mdl_cnt++;
        end else begin
            mdl_err = 1'b1;
        end
        if (done) mdl_run = 1'b1;
        tick();
        load_en = 1'b0;
        load_done = 1'b0;
        check_status("load");
    endtask

    task automatic pulse_done();
        load_done = 1'b1;
        mdl_run = 1'b1;
        tick();
        load_done = 1'b0;
        check_status("done");
    endtask

    task automatic fetch(input logic [31:0] pc, input logic frz, input logic fl);
        logic [33:0] e;
        logic [33:0] got;
        PC = pc;
        freeze = frz;
        flush = fl;
        if (!mdl_run)                 e = mdl_out;
        else if (fl)                  e = {1'b0, 1'b0, NOP};
        else if (frz)                 e = mdl_out;
        else if (!good_addr(pc))      e = {1'b1, 1'b1, NOP};
        else                          e = {1'b1, 1'b0, mdl_mem[int'(pc >> 2)]};
        mdl_out = e;
        exp_q.push_back(e);
        tick();
        freeze = 1'b0;
        flush = 1'b0;
        got = {instr_valid, addr_fault, Instruction};
        e = exp_q.pop_front();
        check("fetch.instr", 64'(got[31:0]), 64'(e[31:0]));
        check("fetch.valid", 64'(got[33]), 64'(e[33]));
        check("fetch.fault", 64'(got[32]), 64'(e[32]));
    endtask

    task automatic random_fetches(input int n);
        logic [31:0] pc;
        for (int i = 0; i < n; i++) begin
            pc = 32'($urandom_range(0, 70)) << 2;
            if ($urandom_range(0, 7) == 0) pc = pc + 32'($urandom_range(1, 3));
            if ($urandom_range(0, 15) == 0) pc = 32'hFFFFFFFC;
            fetch(pc, $urandom_range(0, 4) == 0, $urandom_range(0, 5) == 0);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        for (int i = 0; i < DEPTH; i++) mdl_mem[i] = NOP;
        mdl_out = {1'b0, 1'b0, NOP};
        mdl_run = 1'b0;
        mdl_cnt = 0;
        mdl_err = 1'b0;
        tick();

        // Phase 1: basic load and run
        do_reset();
        load_word(32'h0, 32'hE3A00014, 1'b0);
        load_word(32'h4, 32'hE3A01A01, 1'b0);
        fetch(32'h0, 1'b0, 1'b0);            // ignored while loading
        check("load.no_fetch", 64'(instr_valid), 64'd0);
        pulse_done();
        fetch(32'h0, 1'b0, 1'b0);
        check("first_fetch", 64'(Instruction), 64'hE3A00014);
        check("first_count", 64'(load_count), 64'd2);
        fetch(32'h4, 1'b0, 1'b0);
        check("seq_pc4", 64'(Instruction), 64'hE3A01A01);
        fetch(32'h0, 1'b0, 1'b0);
        check("seq_pc0", 64'(Instruction), 64'hE3A00014);
        for (int i = 0; i < 3; i++) fetch(32'h4, 1'b1, 1'b0);
        check("freeze_hold", 64'(Instruction), 64'hE3A00014);
        fetch(32'h4, 1'b1, 1'b1);
        check("flush_over_freeze", 64'({instr_valid, Instruction}), 64'({1'b0, NOP}));
        fetch(32'h4, 1'b1, 1'b0);            // freeze keeps the flushed NOP
        fetch(32'h2, 1'b0, 1'b0);
        check("misaligned_fault", 64'(addr_fault), 64'd1);
        fetch(32'd256, 1'b0, 1'b0);
        check("range_fault", 64'({addr_fault, Instruction}), 64'({1'b1, NOP}));
        fetch(32'hFFFFFFFC, 1'b0, 1'b0);
        fetch(32'd252, 1'b0, 1'b0);           // last legal word
        fetch(32'h8, 1'b0, 1'b0);
        check("unloaded_word", 64'({instr_valid, addr_fault, Instruction}), 64'({2'b10, NOP}));
        fetch(32'h3, 1'b0, 1'b0);
        fetch(32'h3, 1'b0, 1'b1);             // flush clears the fault
        random_fetches(30);

        // A write attempted in RUN is rejected
        load_word(32'h0, 32'hDEADBEEF, 1'b0);
        fetch(32'h0, 1'b0, 1'b0);
        check("run_write_ignored", 64'(Instruction), 64'hE3A00014);

        // Phase 2: reset mid-run, contents retained, bad loads
        do_reset();
        load_word(32'd256, 32'h11111111, 1'b0);
        load_word(32'h6, 32'h22222222, 1'b0);
        check("bad_load_count", 64'(load_count), 64'd0);
        load_word(32'h8, 32'h12345678, 1'b1);   // write and load_done together
        fetch(32'h4, 1'b0, 1'b0);
        check("retained_pc4", 64'(Instruction), 64'hE3A01A01);
        fetch(32'h0, 1'b0, 1'b0);
        fetch(32'h8, 1'b0, 1'b0);
        check("load_with_done", 64'(Instruction), 64'h12345678);

        // Phase 3: fill the whole array, count saturation
        do_reset();
        for (int i = 0; i < DEPTH; i++) load_word(32'(i * 4), $urandom, 1'b0);
        load_word(32'h0, 32'hCAFEF00D, 1'b0);
        check("count_saturates", 64'(load_count), 64'(DEPTH));
        pulse_done();
        random_fetches(60);

        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
